// File: rtl/uart_tx.sv
// UART transmitter: serialises a parallel word into start, data (LSB first), optional parity and stop bits.
// Bit timing comes from rising edges of a divided baud clock sampled in the clk domain.
module uart_tx #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_clk,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int unsigned IDX_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int unsigned STOP_W = 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARMED  = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_PARITY = 3'd4;
  localparam logic [2:0] S_STOP   = 3'd5;

  logic [2:0]           r_state;
  logic                 r_baud_prev;
  logic [DATA_BITS-1:0] r_shift;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [STOP_W-1:0]    r_stop_cnt;
  logic                 r_tx;
  logic                 r_tx_ready;
  logic                 r_busy;

  logic [2:0]           w_state_nxt;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic [IDX_W-1:0]     w_bit_idx_nxt;
  logic [STOP_W-1:0]    w_stop_cnt_nxt;
  logic                 w_tx_nxt;
  logic                 w_tick;
  logic                 w_parity;
  logic                 w_last_bit;
  logic                 w_last_stop;

  assign w_tick      = baud_clk & ~r_baud_prev;
  assign w_parity    = (^r_shift) ^ 1'(PARITY_ODD);
  assign w_last_bit  = (r_bit_idx == IDX_W'(DATA_BITS - 1));
  assign w_last_stop = (r_stop_cnt == STOP_W'(STOP_BITS - 1));

  // Ready/busy are registered from the next state so they track the state register exactly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_baud_prev <= 1'b1;
      r_shift     <= '0;
      r_bit_idx   <= '0;
      r_stop_cnt  <= '0;
      r_tx        <= 1'b1;
      r_tx_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_baud_prev <= baud_clk;
      r_shift     <= w_shift_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_stop_cnt  <= w_stop_cnt_nxt;
      r_tx        <= w_tx_nxt;
      r_tx_ready  <= (w_state_nxt == S_IDLE);
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_bit_idx_nxt  = r_bit_idx;
    w_stop_cnt_nxt = r_stop_cnt;
    w_tx_nxt       = r_tx;
    case (r_state)
      S_IDLE: begin
        // A tick coinciding with acceptance is deliberately not consumed here.
        if (tx_valid) begin
          w_state_nxt = S_ARMED;
          w_shift_nxt = tx_data;
        end
      end
      S_ARMED: begin
        if (w_tick) begin
          w_state_nxt = S_START;
          w_tx_nxt    = 1'b0;
        end
      end
      S_START: begin
        if (w_tick) begin
          w_state_nxt   = S_DATA;
          w_tx_nxt      = r_shift[0];
          w_bit_idx_nxt = '0;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          if (!w_last_bit) begin
            w_tx_nxt      = r_shift[r_bit_idx + IDX_W'(1)];
            w_bit_idx_nxt = r_bit_idx + IDX_W'(1);
          end else if (PARITY_EN != 0) begin
            w_state_nxt = S_PARITY;
            w_tx_nxt    = w_parity;
          end else begin
            w_state_nxt    = S_STOP;
            w_tx_nxt       = 1'b1;
            w_stop_cnt_nxt = '0;
          end
        end
      end
      S_PARITY: begin
        if (w_tick) begin
          w_state_nxt    = S_STOP;
          w_tx_nxt       = 1'b1;
          w_stop_cnt_nxt = '0;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (w_last_stop) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_stop_cnt_nxt = r_stop_cnt + STOP_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  assign tx       = r_tx;
  assign tx_ready = r_tx_ready;
  assign busy     = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four configurations share one clock, reset and a divide-by-10 baud clock.
// Frames are captured from the line and compared with a bit-list model built from the frame format.
module tb_uart_tx;

  localparam int unsigned BAUD = 10;

  logic       clk;
  logic       reset;
  logic       baud_clk;
  logic [3:0] valid;
  logic [7:0] data [4];
  logic [3:0] tx_o;
  logic [3:0] rdy_o;
  logic [3:0] busy_o;

  int n_tests;
  int n_fail;
  int cyc;
  int baud_cnt;

  // Capture results
  logic obs_val [16];
  bit   cap_stable;
  bit   cap_timeout;
  int   cap_lat;
  int   cap_c0;
  bit   busy_hold;
  logic busy_acc;
  logic rdy_end_pre;
  logic rdy_end_post;
  logic busy_end_post;

  // Reference frame
  logic exp_bits [16];
  int   exp_len;

  uart_tx u_def (
    .clk(clk), .reset(reset), .baud_clk(baud_clk), .tx_data(data[0]), .tx_valid(valid[0]),
    .tx_ready(rdy_o[0]), .tx(tx_o[0]), .busy(busy_o[0])
  );
  uart_tx #(.PARITY_EN(1), .PARITY_ODD(0)) u_even (
    .clk(clk), .reset(reset), .baud_clk(baud_clk), .tx_data(data[1]), .tx_valid(valid[1]),
    .tx_ready(rdy_o[1]), .tx(tx_o[1]), .busy(busy_o[1])
  );
  uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) u_odd (
    .clk(clk), .reset(reset), .baud_clk(baud_clk), .tx_data(data[2]), .tx_valid(valid[2]),
    .tx_ready(rdy_o[2]), .tx(tx_o[2]), .busy(busy_o[2])
  );
  uart_tx #(.STOP_BITS(2)) u_stop2 (
    .clk(clk), .reset(reset), .baud_clk(baud_clk), .tx_data(data[3]), .tx_valid(valid[3]),
    .tx_ready(rdy_o[3]), .tx(tx_o[3]), .busy(busy_o[3])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in for the clock divider: 5 high, 5 low, resets high.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud_cnt <= 0;
      baud_clk <= 1'b1;
    end else begin
      baud_cnt <= (baud_cnt == BAUD - 1) ? 0 : baud_cnt + 1;
      baud_clk <= (baud_cnt == BAUD - 1) || (baud_cnt < 4);
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Frame = start 0, data LSB first, optional parity, stop bits of 1.
  task automatic model_frame(input logic [7:0] d, input int pen, input int podd, input int nstop);
    exp_len = 0;
    exp_bits[exp_len] = 1'b0;
    exp_len = exp_len + 1;
    for (int i = 0; i < 8; i++) begin
      exp_bits[exp_len] = (d / (1 << i)) % 2 == 1;
      exp_len = exp_len + 1;
    end
    if (pen != 0) begin
      exp_bits[exp_len] = (($countones(d) + podd) % 2) == 1;
      exp_len = exp_len + 1;
    end
    for (int s = 0; s < nstop; s++) begin
      exp_bits[exp_len] = 1'b1;
      exp_len = exp_len + 1;
    end
  endtask

  // Sends one word on instance id and records the line one bit time at a time.
  task automatic capture(input int id, input logic [7:0] d, input int nbits, input int inj_bit);
    int w;
    cap_timeout = 0;
    cap_stable  = 1;
    busy_hold   = 1;
    for (int k = 0; k < 16; k++) obs_val[k] = 1'bx;
    w = 0;
    while (rdy_o[id] !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (rdy_o[id] !== 1'b1) begin
      cap_timeout = 1;
      return;
    end
    data[id]  = d;
    valid[id] = 1'b1;
    @(negedge clk);
    valid[id] = 1'b0;
    data[id]  = 8'($urandom_range(255, 0));
    busy_acc  = busy_o[id];
    cap_lat   = 0;
    while (tx_o[id] !== 1'b0 && cap_lat < 30) begin
      @(negedge clk);
      cap_lat++;
    end
    if (tx_o[id] !== 1'b0) begin
      cap_timeout = 1;
      return;
    end
    cap_c0 = cyc;
    for (int k = 0; k < nbits; k++) begin
      for (int c = 0; c < int'(BAUD); c++) begin
        if (c == 0) obs_val[k] = tx_o[id];
        else if (tx_o[id] !== obs_val[k]) cap_stable = 0;
        if (busy_o[id] !== 1'b1) busy_hold = 0;
        if (k == inj_bit && c == 3) begin
          valid[id] = 1'b1;
          data[id]  = 8'hFF;
        end
        if (k == inj_bit && c == 4) valid[id] = 1'b0;
        if (!(k == nbits - 1 && c == int'(BAUD) - 1)) @(negedge clk);
      end
    end
    rdy_end_pre = rdy_o[id];
    @(negedge clk);
    rdy_end_post  = rdy_o[id];
    busy_end_post = busy_o[id];
  endtask

  task automatic test_reset;
    bit bad_tx, bad_rdy, bad_busy;
    reset = 1'b0;
    valid = 4'hF;
    for (int i = 0; i < 4; i++) data[i] = 8'($urandom_range(255, 0));
    bad_tx = 0; bad_rdy = 0; bad_busy = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_o !== 4'hF) bad_tx = 1;
      if (rdy_o !== 4'hF) bad_rdy = 1;
      if (busy_o !== 4'h0) bad_busy = 1;
    end
    n_tests++; if (bad_tx)   begin n_fail++; $display("FAIL reset_tx: got %b want 1111", tx_o); end
    n_tests++; if (bad_rdy)  begin n_fail++; $display("FAIL reset_rdy: got %b want 1111", rdy_o); end
    n_tests++; if (bad_busy) begin n_fail++; $display("FAIL reset_busy: got %b want 0000", busy_o); end
    valid = 4'h0;
    reset = 1'b1;
    bad_tx = 0; bad_rdy = 0; bad_busy = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_o !== 4'hF) bad_tx = 1;
      if (rdy_o !== 4'hF) bad_rdy = 1;
      if (busy_o !== 4'h0) bad_busy = 1;
    end
    n_tests++;
    if (bad_tx || bad_rdy || bad_busy) begin
      n_fail++;
      $display("FAIL post_reset_idle: tx=%b rdy=%b busy=%b want 1111/1111/0000", tx_o, rdy_o, busy_o);
    end
  endtask

  task automatic test_frame_55;
    model_frame(8'h55, 0, 0, 1);
    capture(0, 8'h55, exp_len, -1);
    n_tests++;
    if (cap_timeout) begin
      n_fail++; $display("FAIL f55_timeout: no frame seen, want start bit");
    end else begin
      for (int k = 0; k < exp_len; k++) begin
        n_tests++;
        if (obs_val[k] !== exp_bits[k]) begin
          n_fail++; $display("FAIL f55_bit%0d: got %b want %b", k, obs_val[k], exp_bits[k]);
        end
      end
      n_tests++; if (!cap_stable) begin n_fail++; $display("FAIL f55_hold: bit not held %0d cycles", BAUD); end
      n_tests++; if (cap_lat < 1 || cap_lat > int'(BAUD)) begin n_fail++; $display("FAIL f55_latency: got %0d want 1..%0d", cap_lat, BAUD); end
      n_tests++; if (busy_acc !== 1'b1 || !busy_hold) begin n_fail++; $display("FAIL f55_busy: acc=%b hold=%0d want 1/1", busy_acc, busy_hold); end
      n_tests++; if (rdy_end_pre !== 1'b0 || rdy_end_post !== 1'b1) begin n_fail++; $display("FAIL f55_ready: pre=%b post=%b want 0/1", rdy_end_pre, rdy_end_post); end
      n_tests++; if (busy_end_post !== 1'b0) begin n_fail++; $display("FAIL f55_busy_end: got %b want 0", busy_end_post); end
    end
  endtask

  task automatic test_parity;
    logic [7:0] d;
    for (int id = 1; id <= 2; id++) begin
      for (int r = 0; r < 3; r++) begin
        d = (r == 0) ? 8'h07 : 8'($urandom_range(255, 0));
        model_frame(d, 1, id - 1, 1);
        capture(id, d, exp_len, -1);
        n_tests++;
        if (cap_timeout) begin
          n_fail++; $display("FAIL par%0d_timeout: byte %h not sent", id, d);
        end else begin
          for (int k = 0; k < exp_len; k++) begin
            n_tests++;
            if (obs_val[k] !== exp_bits[k]) begin
              n_fail++; $display("FAIL par%0d_bit%0d: byte %h got %b want %b", id, k, d, obs_val[k], exp_bits[k]);
            end
          end
          n_tests++; if (!cap_stable) begin n_fail++; $display("FAIL par%0d_hold: byte %h bit not held", id, d); end
          n_tests++;
          if (rdy_end_pre !== 1'b0 || rdy_end_post !== 1'b1) begin
            n_fail++; $display("FAIL par%0d_len: pre=%b post=%b want 0/1 after 11 bits", id, rdy_end_pre, rdy_end_post);
          end
        end
      end
    end
  endtask

  task automatic test_stop2;
    logic [7:0] d;
    for (int r = 0; r < 2; r++) begin
      d = (r == 0) ? 8'hA3 : 8'($urandom_range(255, 0));
      model_frame(d, 0, 0, 2);
      capture(3, d, exp_len, -1);
      n_tests++;
      if (cap_timeout) begin
        n_fail++; $display("FAIL stop2_timeout: byte %h not sent", d);
      end else begin
        for (int k = 0; k < exp_len; k++) begin
          n_tests++;
          if (obs_val[k] !== exp_bits[k]) begin
            n_fail++; $display("FAIL stop2_bit%0d: byte %h got %b want %b", k, d, obs_val[k], exp_bits[k]);
          end
        end
        n_tests++; if (!cap_stable) begin n_fail++; $display("FAIL stop2_hold: byte %h bit not held", d); end
        n_tests++;
        if (rdy_end_pre !== 1'b0 || rdy_end_post !== 1'b1) begin
          n_fail++; $display("FAIL stop2_ready: pre=%b post=%b want 0/1", rdy_end_pre, rdy_end_post);
        end
      end
    end
  endtask

  task automatic test_random;
    int id;
    logic [7:0] d;
    for (int r = 0; r < 8; r++) begin
      id = $urandom_range(3, 0);
      d  = 8'($urandom_range(255, 0));
      repeat ($urandom_range(9, 0)) @(negedge clk);
      model_frame(d, (id == 1 || id == 2) ? 1 : 0, (id == 2) ? 1 : 0, (id == 3) ? 2 : 1);
      capture(id, d, exp_len, -1);
      n_tests++;
      if (cap_timeout) begin
        n_fail++; $display("FAIL rnd%0d_timeout: inst %0d byte %h", r, id, d);
      end else begin
        for (int k = 0; k < exp_len; k++) begin
          n_tests++;
          if (obs_val[k] !== exp_bits[k]) begin
            n_fail++; $display("FAIL rnd%0d_bit%0d: inst %0d byte %h got %b want %b", r, k, id, d, obs_val[k], exp_bits[k]);
          end
        end
        n_tests++;
        if (!cap_stable || cap_lat < 1 || cap_lat > int'(BAUD)) begin
          n_fail++; $display("FAIL rnd%0d_timing: stable=%0d lat=%0d want 1 and 1..%0d", r, cap_stable, cap_lat, BAUD);
        end
        n_tests++;
        if (rdy_end_pre !== 1'b0 || rdy_end_post !== 1'b1 || busy_end_post !== 1'b0) begin
          n_fail++; $display("FAIL rnd%0d_end: rdy %b->%b busy %b want 0->1 busy 0", r, rdy_end_pre, rdy_end_post, busy_end_post);
        end
      end
    end
  endtask

  task automatic test_ignore_valid;
    bit extra;
    model_frame(8'h00, 0, 0, 1);
    capture(0, 8'h00, exp_len, 4);
    n_tests++;
    if (cap_timeout) begin
      n_fail++; $display("FAIL ign_timeout: 0x00 frame not sent");
    end else begin
      for (int k = 0; k < exp_len; k++) begin
        n_tests++;
        if (obs_val[k] !== exp_bits[k]) begin
          n_fail++; $display("FAIL ign_bit%0d: got %b want %b", k, obs_val[k], exp_bits[k]);
        end
      end
      extra = 0;
      repeat (40) begin
        @(negedge clk);
        if (tx_o[0] !== 1'b1 || rdy_o[0] !== 1'b1 || busy_o[0] !== 1'b0) extra = 1;
      end
      n_tests++;
      if (extra) begin n_fail++; $display("FAIL ign_extra: line left idle after frame, want tx=1 ready=1"); end
    end
  endtask

  task automatic test_back_to_back;
    int c_first;
    logic [7:0] d;
    d = 8'($urandom_range(255, 0));
    model_frame(d, 0, 0, 1);
    capture(0, d, exp_len, -1);
    c_first = cap_c0;
    n_tests++;
    if (cap_timeout) begin
      n_fail++; $display("FAIL b2b_first_timeout: byte %h", d);
    end else begin
      d = 8'($urandom_range(255, 0));
      model_frame(d, 0, 0, 1);
      capture(0, d, exp_len, -1);
      n_tests++;
      if (cap_timeout) begin
        n_fail++; $display("FAIL b2b_second_timeout: byte %h", d);
      end else begin
        n_tests++;
        if (cap_c0 - c_first !== (exp_len + 1) * int'(BAUD)) begin
          n_fail++; $display("FAIL b2b_gap: got %0d cycles want %0d", cap_c0 - c_first, (exp_len + 1) * int'(BAUD));
        end
        for (int k = 0; k < exp_len; k++) begin
          n_tests++;
          if (obs_val[k] !== exp_bits[k]) begin
            n_fail++; $display("FAIL b2b_bit%0d: byte %h got %b want %b", k, d, obs_val[k], exp_bits[k]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_midframe;
    int w;
    logic [7:0] d;
    d = 8'($urandom_range(255, 0)) & 8'hF7;
    w = 0;
    while (rdy_o[0] !== 1'b1 && w < 200) begin @(negedge clk); w++; end
    data[0]  = d;
    valid[0] = 1'b1;
    @(negedge clk);
    valid[0] = 1'b0;
    w = 0;
    while (tx_o[0] !== 1'b0 && w < 30) begin @(negedge clk); w++; end
    n_tests++;
    if (tx_o[0] !== 1'b0) begin
      n_fail++; $display("FAIL mrst_start: got tx=%b want 0", tx_o[0]);
    end else begin
      model_frame(d, 0, 0, 1);
      repeat (4 * BAUD + 5) @(negedge clk);
      n_tests++;
      if (tx_o[0] !== exp_bits[4]) begin n_fail++; $display("FAIL mrst_bit3: got %b want %b", tx_o[0], exp_bits[4]); end
    end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if ({tx_o[0], rdy_o[0], busy_o[0]} !== 3'b110) begin
      n_fail++; $display("FAIL mrst_async: tx/rdy/busy got %b want 110", {tx_o[0], rdy_o[0], busy_o[0]});
    end
    @(negedge clk);
    reset = 1'b1;
    model_frame(8'h81, 0, 0, 1);
    capture(0, 8'h81, exp_len, -1);
    n_tests++;
    if (cap_timeout) begin
      n_fail++; $display("FAIL mrst_81_timeout: 0x81 not sent");
    end else begin
      for (int k = 0; k < exp_len; k++) begin
        n_tests++;
        if (obs_val[k] !== exp_bits[k]) begin
          n_fail++; $display("FAIL mrst_81_bit%0d: got %b want %b", k, obs_val[k], exp_bits[k]);
        end
      end
      n_tests++;
      if (!cap_stable || rdy_end_post !== 1'b1) begin
        n_fail++; $display("FAIL mrst_81_end: stable=%0d rdy=%b want 1/1", cap_stable, rdy_end_post);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    reset   = 1'b0;
    valid   = 4'h0;
    for (int i = 0; i < 4; i++) data[i] = 8'h00;
    test_reset();
    test_frame_55();
    test_parity();
    test_stop2();
    test_random();
    test_ignore_valid();
    test_back_to_back();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
